// File: rtl/wave_profile_sequencer_pkg.sv
// wave_profile_sequencer_pkg
//   Shared definitions for the wave profile sequencer: the sequencer state
//   enumeration and the default config/dwell widths.
package wave_profile_sequencer_pkg;

    localparam int unsigned CFG_W_DEFAULT   = 13;
    localparam int unsigned DWELL_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/wave_profile_sequencer_if.sv
// wave_profile_sequencer_if
//   Bundles the table-write, control and function-generator output signals
//   of the wave profile sequencer.
//   master modport : drives wr_*, start, stop, loop_en; observes outputs
//   slave modport  : the sequencer side (inputs above, drives cfg_out,
//                    cfg_valid, entry_idx, busy, done, wr_err)
interface wave_profile_sequencer_if
    import wave_profile_sequencer_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned CFG_W       = CFG_W_DEFAULT,
    parameter int unsigned DWELL_W     = DWELL_W_DEFAULT
) ();
    localparam int unsigned AW = $clog2(NUM_ENTRIES);

    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [CFG_W-1:0]   wr_cfg;
    logic [DWELL_W-1:0] wr_dwell;
    logic               start;
    logic               stop;
    logic               loop_en;
    logic [CFG_W-1:0]   cfg_out;
    logic               cfg_valid;
    logic [AW-1:0]      entry_idx;
    logic               busy;
    logic               done;
    logic               wr_err;

    modport master (
        output wr_en, wr_addr, wr_cfg, wr_dwell, start, stop, loop_en,
        input  cfg_out, cfg_valid, entry_idx, busy, done, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_cfg, wr_dwell, start, stop, loop_en,
        output cfg_out, cfg_valid, entry_idx, busy, done, wr_err
    );
endinterface

// File: rtl/wave_profile_sequencer_dwell.sv
// dwell_counter
//   Per-entry dwell down-counter. A load of 0 is stored as 1 so every entry
//   lasts at least one cycle.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : load load_val_i (takes priority over dec_i)
//   load_val_i  : dwell value to load
//   dec_i       : decrement (saturates at 1)
//   tc_o        : terminal count, high when the count is 1
module dwell_counter #(
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_val_i,
    input  logic               dec_i,
    output logic               tc_o
);
    logic [DWELL_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = (load_val_i == '0) ? DWELL_W'(1) : load_val_i;
        end else if (dec_i && count_q > DWELL_W'(1)) begin
            count_d = count_q - DWELL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign tc_o = (count_q == DWELL_W'(1));
endmodule

// File: rtl/wave_profile_sequencer.sv
// wave_profile_sequencer
//   Steps a function generator through a small table of {config, dwell}
//   entries. Table writes are accepted only in IDLE; writes while a sequence
//   is active are dropped and flagged on wr_err.
//   clk  : system clock (rising edge)
//   rst  : asynchronous active-low reset (clears outputs and table)
//   bus  : slave side of wave_profile_sequencer_if (writes, control, outputs)
module wave_profile_sequencer
    import wave_profile_sequencer_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned CFG_W       = CFG_W_DEFAULT,
    parameter int unsigned DWELL_W     = DWELL_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    wave_profile_sequencer_if.slave  bus
);
    localparam int unsigned    AW       = $clog2(NUM_ENTRIES);
    localparam logic [AW-1:0]  LAST_IDX = AW'(NUM_ENTRIES - 1);

    logic [CFG_W-1:0]   tbl_cfg_q   [NUM_ENTRIES];
    logic [DWELL_W-1:0] tbl_dwell_q [NUM_ENTRIES];

    seq_state_t         state_q, state_d;
    logic [CFG_W-1:0]   cfg_q, cfg_d;
    logic               valid_q, valid_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic               done_q, done_d;
    logic               wr_err_q, wr_err_d;

    logic               cnt_load, cnt_dec, cnt_tc;
    logic [DWELL_W-1:0] cnt_val;
    logic [AW-1:0]      nxt_idx;

    assign nxt_idx  = (idx_q == LAST_IDX) ? '0 : idx_q + AW'(1);
    assign wr_err_d = bus.wr_en && (state_q != IDLE);

    dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .tc_o       (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                tbl_cfg_q[i]   <= '0;
                tbl_dwell_q[i] <= '0;
            end
        end else if (bus.wr_en && state_q == IDLE) begin
            tbl_cfg_q[bus.wr_addr]   <= bus.wr_cfg;
            tbl_dwell_q[bus.wr_addr] <= bus.wr_dwell;
        end
    end

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d  = RUN;
                    valid_d  = 1'b1;
                    idx_d    = '0;
                    cnt_load = 1'b1;
                    // A same-cycle write to entry 0 bypasses the table so the
                    // start picks up the value being written.
                    if (bus.wr_en && bus.wr_addr == '0) begin
                        cfg_d   = bus.wr_cfg;
                        cnt_val = bus.wr_dwell;
                    end else begin
                        cfg_d   = tbl_cfg_q[0];
                        cnt_val = tbl_dwell_q[0];
                    end
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else if (!cnt_tc) begin
                    cnt_dec = 1'b1;
                end else if (idx_q != LAST_IDX || bus.loop_en) begin
                    idx_d    = nxt_idx;
                    cfg_d    = tbl_cfg_q[nxt_idx];
                    cnt_val  = tbl_dwell_q[nxt_idx];
                    cnt_load = 1'b1;
                end else begin
                    state_d = DONE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cfg_q    <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign bus.cfg_out   = cfg_q;
    assign bus.cfg_valid = valid_q;
    assign bus.entry_idx = idx_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.wr_err    = wr_err_q;
endmodule

// File: tb/tb_wave_profile_sequencer.sv
module tb_wave_profile_sequencer;
    import wave_profile_sequencer_pkg::*;

    localparam int N  = 4;
    localparam int CW = 13;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    wave_profile_sequencer_if #(.NUM_ENTRIES(N), .CFG_W(CW), .DWELL_W(DW)) bus ();

    wave_profile_sequencer #(.NUM_ENTRIES(N), .CFG_W(CW), .DWELL_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] cfg;
        logic          valid;
        logic [1:0]    idx;
        logic          busy;
        logic          done;
    } obs_t;

    typedef struct {
        string tag;
        bit    loop_en;
        int    stop_at;      // cycle index at which stop is driven, -1 = never
        int    total;        // cycles observed after the start edge
        int    exp_done;     // expected number of done pulses
    } vec_t;

    obs_t          sb_q[$];
    vec_t          vecs[3];
    int            pass_cnt = 0;
    int            chk_cnt  = 0;
    logic [CW-1:0] ref_cfg[N];
    logic [DW-1:0] ref_dw[N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int dw1(input logic [DW-1:0] d);
        return (d == '0) ? 1 : int'(d);
    endfunction

    task automatic idle_inputs();
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_cfg = '0; bus.wr_dwell = '0;
        bus.start = 0; bus.stop = 0; bus.loop_en = 0;
    endtask

    task automatic write_entry(input int a, input logic [CW-1:0] c, input logic [DW-1:0] d);
        bus.wr_en = 1; bus.wr_addr = 2'(a); bus.wr_cfg = c; bus.wr_dwell = d;
        @(negedge clk);
        bus.wr_en = 0;
        ref_cfg[a] = c;
        ref_dw[a]  = d;
    endtask

    // Expected per-cycle observation for a sequence started from IDLE.
    task automatic build_expect(input bit lp, input int stop_at, input int total);
        int e = 0;
        int rem = dw1(ref_dw[0]);
        int st = 1;                  // 0 idle, 1 run, 2 done
        obs_t o;
        for (int c = 0; c < total; c++) begin
            o.cfg = ref_cfg[e]; o.idx = 2'(e);
            o.valid = (st == 1); o.busy = (st == 1); o.done = (st == 2);
            sb_q.push_back(o);
            if (st == 1) begin
                if (c == stop_at) st = 0;
                else if (rem > 1) rem--;
                else if (e < N - 1) begin e++; rem = dw1(ref_dw[e]); end
                else if (lp) begin e = 0; rem = dw1(ref_dw[0]); end
                else st = 2;
            end else if (st == 2) st = 0;
        end
    endtask

    task automatic run_scenario(input vec_t v);
        obs_t o;
        int   dones = 0;
        build_expect(v.loop_en, v.stop_at, v.total);
        bus.loop_en = v.loop_en;
        bus.start   = 1;
        @(negedge clk);
        bus.start = 0;
        for (int c = 0; c < v.total; c++) begin
            o = sb_q.pop_front();
            check($sformatf("%s c%0d cfg_out", v.tag, c), 32'(bus.cfg_out), 32'(o.cfg));
            check($sformatf("%s c%0d cfg_valid", v.tag, c), 32'(bus.cfg_valid), 32'(o.valid));
            check($sformatf("%s c%0d entry_idx", v.tag, c), 32'(bus.entry_idx), 32'(o.idx));
            check($sformatf("%s c%0d busy", v.tag, c), 32'(bus.busy), 32'(o.busy));
            check($sformatf("%s c%0d done", v.tag, c), 32'(bus.done), 32'(o.done));
            if (bus.done === 1'b1) dones++;
            bus.stop = (c == v.stop_at);
            @(negedge clk);
        end
        check($sformatf("%s done pulses", v.tag), 32'(dones), 32'(v.exp_done));
        bus.stop = 1;
        @(negedge clk);
        bus.stop = 0; bus.loop_en = 0;
        check($sformatf("%s idle after", v.tag), 32'(bus.busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " cfg_out"},   32'(bus.cfg_out),   32'd0);
        check({tag, " cfg_valid"}, 32'(bus.cfg_valid), 32'd0);
        check({tag, " entry_idx"}, 32'(bus.entry_idx), 32'd0);
        check({tag, " busy"},      32'(bus.busy),      32'd0);
        check({tag, " done"},      32'(bus.done),      32'd0);
        check({tag, " wr_err"},    32'(bus.wr_err),    32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{tag: "oneshot", loop_en: 1'b0, stop_at: -1, total: 10, exp_done: 1};
        vecs[1] = '{tag: "loop",    loop_en: 1'b1, stop_at: -1, total: 16, exp_done: 0};
        vecs[2] = '{tag: "stop",    loop_en: 1'b0, stop_at: 1,  total: 4,  exp_done: 0};

        idle_inputs();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1;
        @(negedge clk);

        write_entry(0, 13'h0232, 16'd3);
        write_entry(1, 13'h0A32, 16'd1);
        write_entry(2, 13'h1232, 16'd0);
        write_entry(3, 13'h1A32, 16'd2);

        foreach (vecs[i]) run_scenario(vecs[i]);

        // start and stop together in IDLE
        bus.start = 1; bus.stop = 1;
        @(negedge clk);
        bus.start = 0; bus.stop = 0;
        check("start+stop busy", 32'(bus.busy), 32'd0);
        check("start+stop valid", 32'(bus.cfg_valid), 32'd0);

        // write while running is rejected
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        check("wrrun busy", 32'(bus.busy), 32'd1);
        bus.wr_en = 1; bus.wr_addr = 2'd1; bus.wr_cfg = 13'h1FFF; bus.wr_dwell = 16'd5;
        @(negedge clk);
        bus.wr_en = 0;
        check("wrrun wr_err pulse", 32'(bus.wr_err), 32'd1);
        @(negedge clk);
        check("wrrun wr_err clear", 32'(bus.wr_err), 32'd0);
        bus.stop = 1;
        @(negedge clk);
        bus.stop = 0;
        run_scenario(vecs[0]);

        // write to entry 0 together with start: new value used
        bus.wr_en = 1; bus.wr_addr = 2'd0; bus.wr_cfg = 13'h0555; bus.wr_dwell = 16'd2;
        bus.start = 1;
        @(negedge clk);
        bus.wr_en = 0; bus.start = 0;
        ref_cfg[0] = 13'h0555; ref_dw[0] = 16'd2;
        check("bypass0 c0 cfg", 32'(bus.cfg_out), 32'h0555);
        check("bypass0 c0 valid", 32'(bus.cfg_valid), 32'd1);
        @(negedge clk);
        check("bypass0 c1 cfg", 32'(bus.cfg_out), 32'h0555);
        @(negedge clk);
        check("bypass0 c2 cfg", 32'(bus.cfg_out), 32'h0A32);
        check("bypass0 c2 idx", 32'(bus.entry_idx), 32'd1);
        bus.stop = 1;
        @(negedge clk);
        bus.stop = 0;

        // write to entry 2 together with start: entry 0 unaffected, entry 2 updated
        bus.wr_en = 1; bus.wr_addr = 2'd2; bus.wr_cfg = 13'h1BBB; bus.wr_dwell = 16'd1;
        bus.start = 1;
        @(negedge clk);
        bus.wr_en = 0; bus.start = 0;
        check("write2 c0 cfg", 32'(bus.cfg_out), 32'h0555);
        repeat (3) @(negedge clk);
        check("write2 c3 cfg", 32'(bus.cfg_out), 32'h1BBB);
        check("write2 c3 idx", 32'(bus.entry_idx), 32'd2);
        bus.stop = 1;
        @(negedge clk);
        bus.stop = 0;
        write_entry(0, 13'h0232, 16'd3);
        write_entry(2, 13'h1232, 16'd0);

        // asynchronous reset mid-run
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        @(negedge clk);
        check("pre-reset valid", 32'(bus.cfg_valid), 32'd1);
        #2 rst = 0;
        #1 check_all_zero("async reset");
        @(negedge clk);
        rst = 1;
        foreach (ref_cfg[i]) begin ref_cfg[i] = '0; ref_dw[i] = '0; end
        run_scenario('{tag: "zeroed", loop_en: 1'b0, stop_at: -1, total: 6, exp_done: 1});

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
